// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds two requesters into one UART transmitter
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int LAUNCH_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_par_en,
    input  logic                  req0_par_typ,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_par_en,
    input  logic                  req1_par_typ,
    output logic                  req1_ready,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_par_en,
    output logic                  tx_par_typ,
    output logic                  tx_data_valid,
    output logic                  grant_id,
    output logic                  arb_busy,
    output logic                  done_pulse,
    output logic                  err_pulse
);
    localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        LAUNCH    = 4'b0010,
        WAIT_BUSY = 4'b0100,
        WAIT_DONE = 4'b1000
    } state_t;
    state_t        state, state_nxt;
    logic          last_grant, winner, accept, timeout;
    logic [CW-1:0] cnt;
    // winner selection, next state and combinational strobes
    always_comb begin
        winner    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) && (req0_valid || req1_valid);
        timeout   = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(LAUNCH_TIMEOUT));
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = accept ? LAUNCH : IDLE;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: state_nxt = tx_busy ? WAIT_DONE : (timeout ? IDLE : WAIT_BUSY);
            WAIT_DONE: state_nxt = tx_busy ? WAIT_DONE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    assign req0_ready    = (state == IDLE) && req0_valid && !winner;
    assign req1_ready    = (state == IDLE) && req1_valid && winner;
    assign tx_data_valid = (state == LAUNCH);
    assign arb_busy      = (state != IDLE);
    assign err_pulse     = timeout;
    // state register and round-robin history; last_grant moves only on accept
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= accept ? winner : last_grant;
        end
    end
    // capture the winning byte and its parity setup, held until the next accept
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tx_p_data  <= '0;
            tx_par_en  <= 1'b0;
            tx_par_typ <= 1'b0;
            grant_id   <= 1'b0;
        end else if (accept) begin
            tx_p_data  <= winner ? req1_data : req0_data;
            tx_par_en  <= winner ? req1_par_en : req0_par_en;
            tx_par_typ <= winner ? req1_par_typ : req0_par_typ;
            grant_id   <= winner;
        end
    end
    // launch timeout counter: cleared while launching, saturating while waiting for busy
    always_ff @(posedge CLK) begin
        if (!RST || state == LAUNCH)
            cnt <= '0;
        else if (state == WAIT_BUSY && cnt != CW'(LAUNCH_TIMEOUT))
            cnt <= cnt + CW'(1);
    end
    // completion strobe lands in the first IDLE cycle after the transmitter goes idle
    always_ff @(posedge CLK) begin
        if (!RST)
            done_pulse <= 1'b0;
        else
            done_pulse <= (state == WAIT_DONE) && !tx_busy;
    end
endmodule
